// File: rtl/audio_pkg.sv
// Shared audio constants and types for the I2S speaker path.
// Optional build macro in speaker_ctrl: SPK_UNDERRUN_CNT_EN.
package audio_pkg;

    localparam int AUD_SAMPLE_W     = 16;
    localparam int AUD_SLOT_W       = 32;
    localparam int AUD_CLK_PER_SCK  = 16;
    localparam int AUD_CLK_PER_MCLK = 4;

    localparam int AUD_FRAME_CNT = 2 * AUD_SLOT_W * AUD_CLK_PER_SCK;
    localparam int AUD_CNT_W     = $clog2(AUD_FRAME_CNT);

    localparam int AUD_MCLK_BIT  = $clog2(AUD_CLK_PER_MCLK) - 1;
    localparam int AUD_SCK_BIT   = $clog2(AUD_CLK_PER_SCK) - 1;
    localparam int AUD_BIDX_LSB  = $clog2(AUD_CLK_PER_SCK);
    localparam int AUD_LRCK_BIT  = AUD_CNT_W - 1;

    typedef enum logic {
        SPK_EMPTY  = 1'b0,
        SPK_LOADED = 1'b1
    } spk_state_e;

endpackage

// File: rtl/i2s_clk_gen.sv
// Free-running frame counter with registered MCLK/SCK/LRCK.
// Strobes describe the cycle about to begin so outputs move in step with SCK.
module i2s_clk_gen
    import audio_pkg::*;
#(
    parameter int SLOT_W       = AUD_SLOT_W,
    parameter int CLK_PER_SCK  = AUD_CLK_PER_SCK,
    parameter int CLK_PER_MCLK = AUD_CLK_PER_MCLK,
    parameter int BIDX_W       = $clog2(SLOT_W)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              audio_mclk,
    output logic              audio_sck,
    output logic              audio_lrck,
    output logic [BIDX_W-1:0] bidx,
    output logic              slot_r,
    output logic              sck_fall,
    output logic              frame_end
);

    localparam int FRAME    = 2 * SLOT_W * CLK_PER_SCK;
    localparam int CNT_W    = $clog2(FRAME);
    localparam int MCLK_BIT = $clog2(CLK_PER_MCLK) - 1;
    localparam int SCK_LSB  = $clog2(CLK_PER_SCK);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    assign frame_end = (cnt == CNT_W'(FRAME - 1));
    assign cnt_nxt   = frame_end ? '0 : cnt + 1'b1;

    assign sck_fall = (cnt_nxt[SCK_LSB-1:0] == '0);
    assign bidx     = cnt_nxt[CNT_W-2:SCK_LSB];
    assign slot_r   = cnt_nxt[CNT_W-1];

    // Clock outputs track cnt exactly, but come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            audio_mclk <= 1'b0;
            audio_sck  <= 1'b0;
            audio_lrck <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            audio_mclk <= cnt_nxt[MCLK_BIT];
            audio_sck  <= cnt_nxt[SCK_LSB-1];
            audio_lrck <= cnt_nxt[CNT_W-1];
        end
    end

endmodule

// File: rtl/speaker_ctrl.sv
// I2S transmitter for the Pmod I2S DAC: handshake, frame regs, serializer.
// Define SPK_UNDERRUN_CNT_EN to add underrun_cnt/clear_cnt.
module speaker_ctrl
    import audio_pkg::*;
#(
    parameter int SAMPLE_W     = AUD_SAMPLE_W,
    parameter int SLOT_W       = AUD_SLOT_W,
    parameter int CLK_PER_SCK  = AUD_CLK_PER_SCK,
    parameter int CLK_PER_MCLK = AUD_CLK_PER_MCLK
) (
    input  logic                clk,
    input  logic                rst,
`ifdef SPK_UNDERRUN_CNT_EN
    input  logic                clear_cnt,
    output logic [15:0]         underrun_cnt,
`endif
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] audio_left,
    input  logic [SAMPLE_W-1:0] audio_right,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                frame_start,
    output logic                underrun,
    output logic                audio_mclk,
    output logic                audio_lrck,
    output logic                audio_sck,
    output logic                audio_sdin
);

    localparam int BIDX_W = $clog2(SLOT_W);
    localparam int SEL_W  = $clog2(SAMPLE_W);

    logic [BIDX_W-1:0]   bidx;
    logic                slot_r;
    logic                sck_fall;
    logic                frame_end;
    spk_state_e          state;
    logic                full;
    logic                take;
    logic [SAMPLE_W-1:0] hold_l, hold_r;
    logic [SAMPLE_W-1:0] frame_l, frame_r;
    logic [SAMPLE_W-1:0] word;
    logic [SEL_W-1:0]    sel;
    logic                sdin_nxt;

    i2s_clk_gen #(
        .SLOT_W       (SLOT_W),
        .CLK_PER_SCK  (CLK_PER_SCK),
        .CLK_PER_MCLK (CLK_PER_MCLK),
        .BIDX_W       (BIDX_W)
    ) u_clk_gen (
        .clk        (clk),
        .rst        (rst),
        .audio_mclk (audio_mclk),
        .audio_sck  (audio_sck),
        .audio_lrck (audio_lrck),
        .bidx       (bidx),
        .slot_r     (slot_r),
        .sck_fall   (sck_fall),
        .frame_end  (frame_end)
    );

    assign full         = (state == SPK_LOADED);
    assign sample_ready = ~full;
    assign take         = sample_valid & ~full;

    // Slot bit 0 is the I2S one-bit delay; bits past the sample pad with 0.
    always_comb begin
        word     = slot_r ? frame_r : frame_l;
        sel      = SEL_W'(SAMPLE_W - int'(bidx));
        sdin_nxt = 1'b0;
        if (bidx != '0 && int'(bidx) <= SAMPLE_W)
            sdin_nxt = word[sel];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SPK_EMPTY;
            hold_l      <= '0;
            hold_r      <= '0;
            frame_l     <= '0;
            frame_r     <= '0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            audio_sdin  <= 1'b0;
        end else begin
            frame_start <= frame_end;
            underrun    <= frame_end & ~full;
            if (sck_fall)
                audio_sdin <= sdin_nxt;
            if (take) begin
                hold_l <= audio_left;
                hold_r <= audio_right;
            end
            // A starved frame replays the last pair; mute forces zeros.
            if (frame_end) begin
                frame_l <= enable ? (full ? hold_l : frame_l) : '0;
                frame_r <= enable ? (full ? hold_r : frame_r) : '0;
            end
            unique case (state)
                SPK_EMPTY:  if (sample_valid) state <= SPK_LOADED;
                SPK_LOADED: if (frame_end) state <= SPK_EMPTY;
                default:    state <= SPK_EMPTY;
            endcase
        end
    end

`ifdef SPK_UNDERRUN_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            underrun_cnt <= '0;
        else if (clear_cnt)
            underrun_cnt <= '0;
        else if (underrun && underrun_cnt != 16'hFFFF)
            underrun_cnt <= underrun_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_speaker_ctrl.sv
// Randomized bench for speaker_ctrl against a frame-level reference model.
module tb_speaker_ctrl;
    import audio_pkg::*;

    localparam int W     = AUD_SAMPLE_W;
    localparam int FRAME = AUD_FRAME_CNT;
    localparam int SLOT  = FRAME / 2;
    localparam int SCKP  = AUD_CLK_PER_SCK;
    localparam int MCLKP = AUD_CLK_PER_MCLK;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic [W-1:0] audio_left = '0;
    logic [W-1:0] audio_right = '0;
    logic         sample_valid = 1'b0;
    logic         sample_ready, frame_start, underrun;
    logic         audio_mclk, audio_lrck, audio_sck, audio_sdin;
`ifdef SPK_UNDERRUN_CNT_EN
    logic         clear_cnt = 1'b0;
    logic [15:0]  underrun_cnt;
`endif

    always #5 clk = ~clk;

    speaker_ctrl dut (
        .clk          (clk),
        .rst          (rst),
`ifdef SPK_UNDERRUN_CNT_EN
        .clear_cnt    (clear_cnt),
        .underrun_cnt (underrun_cnt),
`endif
        .enable       (enable),
        .audio_left   (audio_left),
        .audio_right  (audio_right),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .frame_start  (frame_start),
        .underrun     (underrun),
        .audio_mclk   (audio_mclk),
        .audio_lrck   (audio_lrck),
        .audio_sck    (audio_sck),
        .audio_sdin   (audio_sdin)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: position in frame, one-deep holding slot, playing pair.
    int           pos;
    logic         m_full, m_took, m_under, m_fs;
    logic [W-1:0] m_hold_l, m_hold_r, m_cur_l, m_cur_r;
    int           m_ucnt;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (pos %0d, t=%0t)",
                     tag, got, exp, pos, $time);
        end
    endtask

    function automatic void m_reset();
        pos = 0;
        m_full = 1'b0;
        m_took = 1'b0;
        m_under = 1'b0;
        m_fs = 1'b0;
        m_hold_l = '0;
        m_hold_r = '0;
        m_cur_l = '0;
        m_cur_r = '0;
        m_ucnt = 0;
    endfunction

    task automatic m_edge();
        logic fe, full0, under0;
        if (rst) begin
            m_reset();
            return;
        end
        fe = (pos == FRAME - 1);
        full0 = m_full;
        under0 = m_under;
        m_took = sample_valid && !full0;
        if (fe) begin
            if (full0) begin
                m_cur_l = enable ? m_hold_l : '0;
                m_cur_r = enable ? m_hold_r : '0;
                m_full = 1'b0;
            end else if (!enable) begin
                m_cur_l = '0;
                m_cur_r = '0;
            end
        end
        if (m_took) begin
            m_hold_l = audio_left;
            m_hold_r = audio_right;
            m_full = 1'b1;
        end
        m_under = fe && !full0;
        m_fs = fe;
`ifdef SPK_UNDERRUN_CNT_EN
        if (clear_cnt)
            m_ucnt = 0;
        else if (under0 && m_ucnt < 65535)
            m_ucnt++;
`else
        if (under0) m_ucnt = m_ucnt;
`endif
        pos = (pos + 1) % FRAME;
    endtask

    function automatic logic exp_sdin();
        int b;
        logic [W-1:0] w;
        b = (pos % SLOT) / SCKP;
        w = (pos >= SLOT) ? m_cur_r : m_cur_l;
        if (b >= 1 && b <= W)
            return w[W-b];
        return 1'b0;
    endfunction

    task automatic check_all();
        check("mclk", 32'(audio_mclk), 32'((pos / (MCLKP / 2)) % 2));
        check("sck", 32'(audio_sck), 32'((pos / (SCKP / 2)) % 2));
        check("lrck", 32'(audio_lrck), 32'(pos / SLOT));
        check("sdin", 32'(audio_sdin), 32'(exp_sdin()));
        check("ready", 32'(sample_ready), 32'(!m_full));
        check("frame_start", 32'(frame_start), 32'(m_fs));
        check("underrun", 32'(underrun), 32'(m_under));
`ifdef SPK_UNDERRUN_CNT_EN
        check("underrun_cnt", 32'(underrun_cnt), 32'(m_ucnt));
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        m_edge();
        #1;
        check_all();
        if (m_took) begin
            audio_left = W'($urandom);
            audio_right = W'($urandom);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_until(input int p);
        int i;
        for (i = 0; i <= FRAME + 1; i++) begin
            if (pos == p) break;
            cycle();
        end
        if (pos != p) check("run_until_timeout", 32'(pos), 32'(p));
    endtask

    // Present one pair and keep valid up until it is accepted.
    task automatic send(input logic [W-1:0] l, input logic [W-1:0] r);
        int i;
        audio_left = l;
        audio_right = r;
        sample_valid = 1'b1;
        for (i = 0; i < 3 * FRAME; i++) begin
            cycle();
            if (m_took) break;
        end
        sample_valid = 1'b0;
        if (!m_took) check("send_timeout", 32'(m_took), 32'd1);
    endtask

    initial begin
        m_reset();
        // Reset state and idle, starved frames.
        run(3);
        #1 check_all();
        rst = 1'b0;
        enable = 1'b1;
        run(3 * FRAME + 4);

        // Directed pair, loaded early in the frame.
        run_until(100);
        send(16'hF000, 16'h1000);
        run(2 * FRAME);

        // Continuous valid: one pair per frame.
        sample_valid = 1'b1;
        run(3 * FRAME);
        sample_valid = 1'b0;
        run_until(FRAME - 1);
        cycle();
        run_until(FRAME - 1);

        // First valid exactly on the last cycle of a starved frame.
        audio_left = 16'h8001;
        audio_right = 16'h7FFE;
        sample_valid = 1'b1;
        cycle();
        sample_valid = 1'b0;
        run(2 * FRAME);

        // Mute with a pair loaded, then re-enable mid-frame.
        run_until(100);
        enable = 1'b0;
        send(16'h1234, 16'hABCD);
        run_until(100);
        send(16'h5A5A, 16'hC3C3);
        run_until(300);
        enable = 1'b1;
        run(2 * FRAME);

`ifdef SPK_UNDERRUN_CNT_EN
        // Clear coinciding with an underrun pulse.
        run_until(FRAME - 1);
        cycle();
        clear_cnt = 1'b1;
        cycle();
        clear_cnt = 1'b0;
        run(FRAME);
`endif

        // Random traffic.
        for (int i = 0; i < 6 * FRAME; i++) begin
            cycle();
            if (m_took && $urandom_range(0, 1) == 0)
                sample_valid = 1'b0;
            if (!sample_valid && $urandom_range(0, 499) == 0)
                sample_valid = 1'b1;
            if ($urandom_range(0, 2999) == 0)
                enable = ~enable;
`ifdef SPK_UNDERRUN_CNT_EN
            clear_cnt = ($urandom_range(0, 1999) == 0);
`endif
        end
        sample_valid = 1'b0;
        enable = 1'b1;
`ifdef SPK_UNDERRUN_CNT_EN
        clear_cnt = 1'b0;
`endif

        // Asynchronous reset mid right slot.
        send(16'hFFFF, 16'h8000);
        run_until(FRAME - 1);
        cycle();
        run_until(600);
        rst = 1'b1;
        #1;
        m_reset();
        check_all();
        run(2);
        rst = 1'b0;
        send(16'h0F0F, 16'hF0F0);
        run(2 * FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
